// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path
// among NREQ byte requesters, with a per-frame watchdog.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TO_W    = 20,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  input  logic              tx_err,
  output logic              done_valid,
  output logic [IDW-1:0]    done_id,
  output logic              done_err,
  output logic              done_timeout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    ACTIVE,
    REPORT
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  cur_id;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic [TO_W-1:0] wd;
  logic            done_q;
  logic            done_edge;
  logic            wd_exp;
  logic            fin_ok;

  assign done_edge = tx_done & ~done_q;
  assign wd_exp    = (wd == TO_W'(TIMEOUT - 1));
  assign fin_ok    = (state == ACTIVE) & done_edge;

  assign tx_start   = (state == ACTIVE);
  assign done_valid = (state == REPORT);
  assign busy       = (state != IDLE);

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    req_ready = '0;
    if (state == IDLE) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!grant_any &&
            req_valid[(int'(ptr) + k) % NREQ]) begin
          grant_any = 1'b1;
          grant_id  = IDW'((int'(ptr) + k) % NREQ);
        end
      end
      if (grant_any) req_ready[grant_id] = 1'b1;
    end
  end

  // Frame sequencing; watchdog expiry also leaves CLEAR.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (grant_any) state_n = CLEAR;
      end
      CLEAR: begin
        if (wd_exp)        state_n = REPORT;
        else if (!tx_done) state_n = ACTIVE;
      end
      ACTIVE: begin
        if (done_edge || wd_exp) state_n = REPORT;
      end
      REPORT: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, latched frame data, watchdog and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= IDW'(NREQ - 1);
      cur_id       <= '0;
      tx_data      <= '0;
      wd           <= '0;
      done_q       <= 1'b0;
      done_id      <= '0;
      done_err     <= 1'b0;
      done_timeout <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= tx_done;
      unique case (state)
        IDLE: begin
          if (grant_any) begin
            tx_data <= req_data[{grant_id, 3'b000} +: 8];
            cur_id  <= grant_id;
            ptr     <= grant_id;
            wd      <= '0;
          end
        end
        CLEAR, ACTIVE: begin
          wd <= wd + 1'b1;
          if (state_n == REPORT) begin
            done_id      <= cur_id;
            done_err     <= fin_ok ? tx_err : 1'b0;
            done_timeout <= ~fin_ok;
          end
        end
        REPORT: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path of uart_top among NREQ independent byte requesters using round-robin arbitration.
- Sequences each frame: latches the winning byte, raises tx_start, waits for tx_done, reports completion and error status back per requester.
- Sits between on-chip byte producers and the uart_top tx_start/tx_data/tx_done/tx_err pins, in the system clk domain.
- Includes a watchdog so a stalled transmitter cannot lock the arbiter.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester index (clog2(NREQ))
TO_W, 20, width of watchdog counter
TIMEOUT, 1000000, clk cycles allowed per frame (CLEAR+ACTIVE) before abort

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester byte available
req_data  in  8*NREQ  byte for requester i at [8*i+7:8*i]
req_ready  out  NREQ  one-hot accept strobe; transfer when req_valid[i]&req_ready[i]
tx_start  out  1  to uart_top tx_start
tx_data  out  8  to uart_top tx_data, stable while tx_start high
tx_done  in  1  from uart_top tx_done (level, may stay high many clk cycles)
tx_err  in  1  from uart_top tx_err
done_valid  out  1  one-cycle completion strobe
done_id  out  IDW  requester index of completed frame
done_err  out  1  tx_err sampled at completion
done_timeout  out  1  frame aborted by watchdog
busy  out  1  high in any state except IDLE

Behaviour:
- States: IDLE, CLEAR, ACTIVE, REPORT. Reset -> IDLE.
- Reset values: tx_start=0, tx_data=0, req_ready=0, done_valid=0, done_id=0, done_err=0, done_timeout=0, busy=0, rr pointer=NREQ-1 (requester 0 has top priority first), watchdog=0, done_q=0.
- req_ready combinational: nonzero only in IDLE; one-hot on first req_valid index searching from ptr+1 upward, wrapping modulo NREQ. No valid -> all zero.
- IDLE: on accept, latch byte into tx_data, latch index into cur_id, ptr<=cur_id, watchdog<=0, go CLEAR next cycle. Accept-to-CLEAR latency 1 cycle.
- CLEAR: tx_start=0; wait until tx_done==0 (discards stale done from previous frame); then go ACTIVE. Watchdog increments.
- ACTIVE: tx_start=1, tx_data held. done_q registers tx_done each cycle. Rising edge (tx_done & ~done_q) -> capture done_err<=tx_err, done_timeout<=0, go REPORT. tx_start drops in the same cycle REPORT is entered (registered).
- Watchdog: increments every cycle in CLEAR/ACTIVE. At value TIMEOUT-1 with no done edge -> done_timeout<=1, done_err<=0, go REPORT. A done edge in the same cycle as expiry wins (normal completion).
- REPORT: done_valid=1 for exactly one cycle, done_id=cur_id, tx_start=0; next state IDLE. done_id/done_err/done_timeout hold until next REPORT.
- No new request is accepted until IDLE: at most one frame outstanding. Back-to-back frame minimum spacing: IDLE, CLEAR(>=1), ACTIVE, REPORT.
- req_valid dropping after accept has no effect. req_valid held with no accept is not an error.
- Reset mid-frame: all outputs return to reset values next edge, frame dropped, no done_valid, ptr returns to NREQ-1.
- tx_err high outside ACTIVE edge cycle is ignored.

Test Plan:
- Reset, req_valid=4'b0001, req_data[7:0]=8'hA5; uart_top returns tx_done -> req_ready=4'b0001 one cycle, tx_data=8'hA5 with tx_start high until done edge, then done_valid=1, done_id=0, done_err=0.
- All four req_valid held high, bytes 8'h10/8'h21/8'h32/8'h43 -> grants in order 0,1,2,3,0, done_id sequence 0,1,2,3,0; tx_data matches each granted byte.
- tx_done already high when frame accepted (stale) -> arbiter stays in CLEAR until low; done_valid only after the new rising edge, exactly one per frame.
- tx_err=1 at the done edge for requester 2 -> done_valid with done_id=2, done_err=1, done_timeout=0.
- TIMEOUT=100, tx_done tied 0 -> done_valid exactly 100 cycles after entering CLEAR, done_timeout=1, tx_start low afterwards, next requester granted.
- Assert rst during ACTIVE -> next cycle tx_start=0, busy=0, no done_valid; after release, req 0 and 3 valid -> requester 0 granted first.
